// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, recovered byte and status pulses out.
// The slave modport is the receiver; the master modport is the line driver / consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data_out;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  modport slave (
    input  rx,
    output rx_data_out, rx_done, frame_err, parity_err, rx_busy
  );

  modport master (
    output rx,
    input  rx_data_out, rx_done, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8-N-1 frames timed by a clock-per-bit counter, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit (11-bit frames) and a live parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              rxs;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              perr_q, perr_d;
  logic              pbad_q, pbad_d;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], bus.rx};
  end

  assign rxs = sync_q[1];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        // A low that has vanished by mid start bit is a glitch, not a frame.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          sh_d[idx_q] = rxs;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          pbad_d  = rxs ^ (^sh_q);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        // Deciding at mid stop bit leaves half a bit of slack to catch a back-to-back start edge.
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (pbad_q) begin
              perr_d = 1'b1;
            end else
`endif
            begin
              data_d = sh_q;
              done_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        // A break (line held low) must not look like a stream of new start bits.
        if (rxs) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_data_out = data_q;
  assign bus.rx_done     = done_q;
  assign bus.frame_err   = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = perr_q;
`else
  assign bus.parity_err  = 1'b0;
`endif
  assign bus.rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks/bit: stimulus pushes expected pulses,
// a negedge monitor pops and compares each rx_done / frame_err / parity_err pulse.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int MID_STOP = (FRAME_BITS - 1) * CPB + CPB / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0] flags;  // {parity_err, frame_err, rx_done}
    logic [7:0] data;   // rx_data_out expected while the pulse is high
  } exp_t;

  exp_t        sb[$];
  int unsigned done_cyc[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every status pulse must match the head of the scoreboard.
  logic [2:0] mon_flags;
  exp_t       mon_exp;
  always @(negedge clk) begin
    if (rst && (bus.rx_done || bus.frame_err || bus.parity_err)) begin
      mon_flags = {bus.parity_err, bus.frame_err, bus.rx_done};
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(mon_flags), 32'h0);
      end else begin
        mon_exp = sb.pop_front();
        check("pulse_kind", 32'(mon_flags), 32'(mon_exp.flags));
        check("rx_data_out", 32'(bus.rx_data_out), 32'(mon_exp.data));
      end
      if (bus.rx_done) done_cyc.push_back(cyc);
    end
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_b);
    send_bit(1'b1);
  endtask
`endif

  int          busy_hits;
  int unsigned t0;
  int unsigned lat;
  int          budget;

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_data",  32'(bus.rx_data_out), 32'h00);
    check("reset_done",  32'(bus.rx_done),     32'h0);
    check("reset_ferr",  32'(bus.frame_err),   32'h0);
    check("reset_perr",  32'(bus.parity_err),  32'h0);
    check("reset_busy",  32'(bus.rx_busy),     32'h0);

    rst = 1'b1;
    busy_hits = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.rx_busy) busy_hits++;
    end
    check("idle_busy_hits", 32'(busy_hits), 32'h0);

    // Single frame A5: rx_done 2-3 clocks after the line's mid stop bit.
    done_cyc.delete();
    sb.push_back('{3'b001, 8'hA5});
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("a5_done_count", 32'(done_cyc.size()), 32'd1);
    lat = (done_cyc.size() > 0) ? done_cyc[0] - t0 : 0;
    check("a5_latency_ok", 32'(lat >= MID_STOP + 2 && lat <= MID_STOP + 3), 32'd1);

    // Back-to-back 3C, FF with zero idle time.
    done_cyc.delete();
    sb.push_back('{3'b001, 8'h3C});
    sb.push_back('{3'b001, 8'hFF});
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_done_count", 32'(done_cyc.size()), 32'd2);
    lat = (done_cyc.size() > 1) ? done_cyc[1] - done_cyc[0] : 0;
    check("b2b_spacing_ok", 32'(lat + 1 >= FRAME_BITS * CPB && lat <= FRAME_BITS * CPB + 1), 32'd1);

    // 55 with a low stop bit, then a 5-bit break: one frame_err, data held, stuck in WAIT_HIGH.
    sb.push_back('{3'b010, 8'hFF});
    send_frame(8'h55, 1'b0);
    repeat (5) send_bit(1'b0);
    check("break_busy", 32'(bus.rx_busy), 32'h1);
    check("break_data", 32'(bus.rx_data_out), 32'hFF);
    send_bit(1'b1);
    check("release_idle", 32'(bus.rx_busy), 32'h0);
    sb.push_back('{3'b001, 8'h12});
    send_frame(8'h12, 1'b1);
    repeat (4) @(negedge clk);

    // 5-cycle glitch: START is entered but abandoned at mid start bit.
    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_detect", 32'(bus.rx_busy), 32'h1);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_idle", 32'(bus.rx_busy), 32'h0);
    check("glitch_data", 32'(bus.rx_data_out), 32'h12);

    // Reset mid-frame aborts immediately.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    #1;
    check("midrst_data", 32'(bus.rx_data_out), 32'h00);
    check("midrst_busy", 32'(bus.rx_busy),     32'h0);
    check("midrst_done", 32'(bus.rx_done),     32'h0);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back('{3'b001, 8'hC3});
    send_frame(8'hC3, 1'b1);
    repeat (4) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 07 has three ones: even parity bit is 1.
    sb.push_back('{3'b100, 8'hC3});
    send_frame_par(8'h07, 1'b0);
    repeat (4) @(negedge clk);
    check("perr_data_held", 32'(bus.rx_data_out), 32'hC3);
    sb.push_back('{3'b001, 8'h07});
    send_frame_par(8'h07, 1'b1);
    repeat (4) @(negedge clk);
`endif

    budget = 2000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART block: recovers 8-N-1 frames (optional even parity) from the asynchronous `rx` line, presents the received byte on `rx_data_out` and flags completion or errors with single-cycle pulses. It is the receive-side counterpart to the UART transmitter, which owns `tx_data_in`, `start`, `tx`, `tx_active` and `done_tx`. Bit timing comes from a clock-per-bit divider; no separate baud clock is used.

## Interface
- `CLKS_PER_BIT`, 87, system clocks per serial bit. Must be ≥ 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, asynchronous, active-low (0 = reset).
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `rx_data_out`  output  8  last correctly received byte; holds until the next good frame.
- `rx_done`  output  1  one-cycle pulse when a good frame has been written to `rx_data_out`.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  output  1  one-cycle pulse on parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.
- `rx_busy`  output  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. The synchronizer resets to 1. All decisions use the synchronized value `rxs`.
- Bit counter `cnt` has width $clog2(CLKS_PER_BIT). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- FSM states:
  - IDLE: if `rxs`==0, go to START with `cnt`=0.
  - START: count to `(CLKS_PER_BIT-1)/2` (mid start bit). If `rxs`==0, go to DATA with `cnt`=0 and `idx`=0. If `rxs`==1, treat it as a glitch and return to IDLE with no pulse.
  - DATA: count to `CLKS_PER_BIT-1`, then sample `rxs` into `sh[idx]` (LSB first) and clear `cnt`. After `idx`==7 is sampled, go to PARITY (macro defined) or STOP.
  - PARITY: count to `CLKS_PER_BIT-1`, then sample the parity bit and go to STOP.
  - STOP: count to `CLKS_PER_BIT-1`, then sample:
    - `rxs`==1 with no parity error: load `rx_data_out`<=`sh`, pulse `rx_done`, go to IDLE.
    - `rxs`==1 with a parity error: pulse `parity_err`, leave `rx_data_out` unchanged, go to IDLE.
    - `rxs`==0: pulse `frame_err`, leave `rx_data_out` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then go to IDLE. This prevents a held-low (break) line from retriggering.
- At most one of `rx_done`, `frame_err` and `parity_err` is high in any cycle.
- Transmitter activity has no effect on this block; full-duplex operation is allowed.

## Timing
- Reset values: `rx_data_out`=8'h00; `rx_done`, `frame_err`, `parity_err` and `rx_busy` all 0; FSM in IDLE; synchronizer flops at 1.
- Reset asserted mid-frame aborts immediately. No pulse is produced, and `rx_data_out` returns to 00.
- Line-to-detect latency: 2 clocks (synchronizer) plus 1 clock (IDLE→START).
- With edge E defined as the first cycle `rxs`==0, data bit n is sampled at E + `(CLKS_PER_BIT-1)/2` + (n+1)·`CLKS_PER_BIT` + 1.
- The stop bit is sampled `CLKS_PER_BIT` cycles after bit 7, or after the parity bit when parity is enabled.
- `rx_done` and `rx_data_out` update on the clock edge after the stop sample. The two are coincident.
- Sampling at mid stop bit and returning straight to IDLE lets a back-to-back start bit (zero idle time) be caught.
- A glitch shorter than half a bit never leaves START.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present.
  - Expected parity bit is ^`sh` (even parity).
  - Frame length is 11 bits.
  - `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; frame is 10 bits (8-N-1).
  - `parity_err` is a constant 0.

## Test plan
- Reset then idle line, `CLKS_PER_BIT`=16:
  - All outputs at reset values.
  - `rx_busy` stays 0 for 1000 cycles.
- Send 8'hA5 as 8-N-1 at 16 clocks/bit:
  - `rx_data_out`=A5 with one `rx_done` pulse, 2-3 cycles after mid stop bit.
  - `frame_err`=0.
- Send 8'h3C and 8'hFF back-to-back with zero idle time:
  - Two `rx_done` pulses, 160±1 cycles apart.
  - `rx_data_out` reads 3C, then FF.
- Send 8'h55 with the stop bit forced low, then hold `rx` low for 5 bits:
  - One `frame_err` pulse, no `rx_done`.
  - `rx_data_out` keeps its prior value.
  - FSM stays in WAIT_HIGH until `rx` is released, then receives 8'h12 correctly.
- Drive a 5-cycle low glitch on `rx`:
  - Back to IDLE, no pulses, `rx_data_out` unchanged.
  - Then pull `rst` low mid-frame: all outputs reset immediately.
- With `UART_RX_PARITY_EN`:
  - Send 8'h07 with parity bit 1: `rx_done` pulses.
  - Send 8'h07 with parity bit 0: `parity_err` pulses, `rx_data_out` unchanged.
